// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, opcodes and
// datapath select values.
package multi_cycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_MUL = 6'h1c;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_LUI = 6'h0f;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_LUI   = 2'd3;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OP_R) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/multi_cycle_control.sv
// Multi-cycle instruction sequencer: steps the shared datapath through
// fetch/decode/execute/memory/write-back and counts retired instructions.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
(
  input  logic        clock,
  input  logic        resetN,
  input  logic [5:0]  opCode,
  input  logic        memReady,
  input  logic        zero,
  output logic        pcWrite,
  output logic        irWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        iorD,
  output logic        regWrite,
  output logic        ALUSrcA,
  output logic [1:0]  regDst,
  output logic [1:0]  memToReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        instrDone,
  output logic        illegalOp,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;

  // State and retired-instruction counter; reset abandons any in-flight access.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

  // Next-state and datapath controls; outputs follow the state register so
  // reset forces them low without waiting for a clock edge.
  always_comb begin
    state_d   = state_q;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    iorD      = 1'b0;
    regWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    regDst    = REGDST_RT;
    memToReg  = M2R_ALUOUT;
    ALUSrcB   = SRCB_B;
    ALUOp     = ALUOP_ADD;
    PCSource  = PCSRC_ALU;
    instrDone = 1'b0;
    illegalOp = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        memRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
        if (memReady) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SL2;
        case (opCode)
          OP_R, OP_MUL, OP_LUI: state_d = S_EXECUTE;
          OP_LW, OP_SW:         state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:       state_d = S_BRANCH;
          OP_J, OP_JAL:         state_d = S_JUMP;
          default:              state_d = S_ILLEGAL;
        endcase
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        if (is_rtype(opCode)) begin
          ALUSrcB = SRCB_B;
          ALUOp   = ALUOP_FUNCT;
        end else begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_LUI;
        end
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        regWrite  = 1'b1;
        regDst    = is_rtype(opCode) ? REGDST_RD : REGDST_RT;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (opCode == OP_SW) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReady) begin
          state_d = S_MEM_WB;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        regWrite  = 1'b1;
        memToReg  = M2R_MDR;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_WRITE: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        instrDone = memReady;
        if (memReady) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALUOP_SUB;
        PCSource  = PCSRC_ALUOUT;
        pcWrite   = (opCode == OP_BNE) ? ~zero : zero;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        if (opCode == OP_JAL) begin
          regWrite = 1'b1;
          regDst   = REGDST_R31;
          memToReg = M2R_PC;
        end else begin
          regWrite = 1'b0;
        end
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: begin
        illegalOp = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter wraps naturally at 32 bits.
  always_comb begin
    if (instrDone) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed self-checking bench for multi_cycle_control.
module tb_multi_cycle_control;

  logic        clock = 1'b0;
  logic        resetN;
  logic [5:0]  opCode;
  logic        memReady;
  logic        zero;
  logic        pcWrite, irWrite, memRead, memWrite, iorD, regWrite, ALUSrcA;
  logic [1:0]  regDst, memToReg, ALUSrcB, ALUOp, PCSource;
  logic        instrDone, illegalOp;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  multi_cycle_control dut (
    .clock(clock), .resetN(resetN), .opCode(opCode), .memReady(memReady), .zero(zero),
    .pcWrite(pcWrite), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
    .iorD(iorD), .regWrite(regWrite), .ALUSrcA(ALUSrcA), .regDst(regDst),
    .memToReg(memToReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instrDone(instrDone), .illegalOp(illegalOp), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [20:0] ctrl_vec();
    return {pcWrite, irWrite, memRead, memWrite, iorD, regWrite, ALUSrcA,
            regDst, memToReg, ALUSrcB, ALUOp, PCSource, instrDone, illegalOp};
  endfunction

  // Entered in FETCH; holds memReady low fw cycles in FETCH and mw cycles in
  // MEM_READ/MEM_WRITE, low everywhere else. Returns in the final cycle.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic z, output int cyc);
    int  fcnt = 0;
    int  mcnt = 0;
    bit  done = 1'b0;
    opCode = op;
    zero   = z;
    cyc    = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (memRead && !iorD) begin
        memReady = (fcnt >= fw);
        fcnt++;
      end else if (iorD) begin
        memReady = (mcnt >= mw);
        mcnt++;
      end else begin
        memReady = 1'b0;
      end
      #1;
      cyc++;
      if (instrDone || illegalOp) begin
        done = 1'b1;
      end else begin
        tick();
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout op=0x%0h: no completion within 64 cycles", op);
    end
  endtask

  int cyc;

  initial begin
    resetN   = 1'b0;
    opCode   = 6'h00;
    memReady = 1'b1;
    zero     = 1'b0;
    #12;
    check_val("reset_ctrl", 32'(ctrl_vec()), 32'd0);
    check_val("reset_retired", retired, 32'd0);

    @(negedge clock);
    resetN = 1'b1;
    #1;
    check_val("idle_ctrl", 32'(ctrl_vec()), 32'd0);
    tick();
    check_val("fetch_memRead", 32'(memRead), 32'd1);
    check_val("fetch_irWrite", 32'(irWrite), 32'd1);
    check_val("fetch_pcWrite", 32'(pcWrite), 32'd1);
    check_val("fetch_srcB", 32'(ALUSrcB), 32'd1);

    // R-type
    run_instr(6'h00, 0, 0, 1'b0, cyc);
    check_val("r_cycles", cyc, 32'd4);
    check_val("r_regWrite", 32'(regWrite), 32'd1);
    check_val("r_regDst", 32'(regDst), 32'd1);
    check_val("r_memToReg", 32'(memToReg), 32'd0);
    tick();
    check_val("r_retired", retired, 32'd1);

    // lw with stalls in fetch and memory read
    run_instr(6'h23, 2, 3, 1'b0, cyc);
    check_val("lw_cycles", cyc, 32'd10);
    check_val("lw_regWrite", 32'(regWrite), 32'd1);
    check_val("lw_memToReg", 32'(memToReg), 32'd1);
    check_val("lw_regDst", 32'(regDst), 32'd0);
    tick();
    check_val("lw_retired", retired, 32'd2);

    // sw with stalls in memory write
    run_instr(6'h2b, 0, 2, 1'b0, cyc);
    check_val("sw_cycles", cyc, 32'd6);
    check_val("sw_memWrite", 32'(memWrite), 32'd1);
    check_val("sw_iorD", 32'(iorD), 32'd1);
    tick();
    check_val("sw_retired", retired, 32'd3);

    // beq taken
    run_instr(6'h04, 0, 0, 1'b1, cyc);
    check_val("beq_cycles", cyc, 32'd3);
    check_val("beq_pcWrite", 32'(pcWrite), 32'd1);
    check_val("beq_PCSource", 32'(PCSource), 32'd1);
    check_val("beq_ALUOp", 32'(ALUOp), 32'd1);
    tick();

    // bne with zero=1: not taken, still completes
    run_instr(6'h05, 0, 0, 1'b1, cyc);
    check_val("bne_pcWrite", 32'(pcWrite), 32'd0);
    check_val("bne_instrDone", 32'(instrDone), 32'd1);
    tick();
    check_val("bne_retired", retired, 32'd5);

    // jal
    run_instr(6'h03, 0, 0, 1'b0, cyc);
    check_val("jal_cycles", cyc, 32'd3);
    check_val("jal_pcWrite", 32'(pcWrite), 32'd1);
    check_val("jal_PCSource", 32'(PCSource), 32'd2);
    check_val("jal_regWrite", 32'(regWrite), 32'd1);
    check_val("jal_regDst", 32'(regDst), 32'd2);
    check_val("jal_memToReg", 32'(memToReg), 32'd2);
    tick();

    // lui
    run_instr(6'h0f, 0, 0, 1'b0, cyc);
    check_val("lui_cycles", cyc, 32'd4);
    check_val("lui_regDst", 32'(regDst), 32'd0);
    check_val("lui_regWrite", 32'(regWrite), 32'd1);
    tick();
    check_val("lui_retired", retired, 32'd7);

    // illegal opcode
    run_instr(6'h3f, 0, 0, 1'b0, cyc);
    check_val("ill_cycles", cyc, 32'd3);
    check_val("ill_illegalOp", 32'(illegalOp), 32'd1);
    check_val("ill_regWrite", 32'(regWrite), 32'd0);
    check_val("ill_memWrite", 32'(memWrite), 32'd0);
    check_val("ill_instrDone", 32'(instrDone), 32'd0);
    tick();
    check_val("ill_retired", retired, 32'd7);
    check_val("ill_next_fetch", 32'(memRead), 32'd1);

    // reset asserted while a store is stalled
    opCode   = 6'h2b;
    memReady = 1'b1;
    tick();
    tick();
    memReady = 1'b0;
    tick();
    check_val("sw_stall_memWrite", 32'(memWrite), 32'd1);
    resetN = 1'b0;
    #1;
    check_val("rst_memWrite", 32'(memWrite), 32'd0);
    check_val("rst_retired", retired, 32'd0);
    check_val("rst_ctrl", 32'(ctrl_vec()), 32'd0);
    @(negedge clock);
    resetN   = 1'b1;
    memReady = 1'b1;
    #1;
    check_val("restart_idle", 32'(ctrl_vec()), 32'd0);
    tick();
    check_val("restart_fetch", 32'(memRead), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
